// File: rtl/ah_dec_pkg.sv
// Shared encodings and reset constants for the range decoder pipeline.
package ah_dec_pkg;

  typedef enum logic [1:0] {
    CFG_BOM  = 2'd0,
    CFG_TOM  = 2'd1,
    CFG_EN   = 2'd2,
    CFG_RSVD = 2'd3
  } cfg_sel_e;

  // Replicated to ADDR_W: bom resets to all-ones and tom to zero, so nothing hits after reset.
  localparam logic BOM_RST_BIT = 1'b1;
  localparam logic TOM_RST_BIT = 1'b0;

endpackage

// File: rtl/ah_range_decoder_pipe_if.sv
// Lookup, result, config and counter signals of the range decoder, grouped for port binding.
interface ah_range_decoder_pipe_if #(
  parameter int ADDR_W      = 57,
  parameter int NUM_CLIENTS = 30,
  parameter int CNT_W       = 16
);
  localparam int SEL_W = $clog2(NUM_CLIENTS);

  // Handshake rule on both in_* and out_*: a transfer happens on a rising edge where
  // valid && ready; a valid producer keeps valid and data stable until that edge.
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      in_addr;
  logic                   out_valid;
  logic                   out_ready;
  logic [SEL_W-1:0]       out_sel;
  logic [NUM_CLIENTS-1:0] out_onehot;
  logic                   out_err;
  logic                   out_multi;
  logic                   cfg_we;
  logic [SEL_W-1:0]       cfg_idx;
  logic [1:0]             cfg_sel;
  logic [ADDR_W-1:0]      cfg_wdata;
  logic                   cfg_err;
  logic [CNT_W-1:0]       err_cnt;
  logic                   err_cnt_clr;

  modport master (
    output in_valid, in_addr, out_ready, cfg_we, cfg_idx, cfg_sel, cfg_wdata, err_cnt_clr,
    input  in_ready, out_valid, out_sel, out_onehot, out_err, out_multi, cfg_err, err_cnt
  );

  modport slave (
    input  in_valid, in_addr, out_ready, cfg_we, cfg_idx, cfg_sel, cfg_wdata, err_cnt_clr,
    output in_ready, out_valid, out_sel, out_onehot, out_err, out_multi, cfg_err, err_cnt
  );
endinterface

// File: rtl/ah_dec_prio_enc.sv
// Combinational lowest-index priority encoder with none/multi flags.
module ah_dec_prio_enc #(
  parameter int N = 30,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          none,
  output logic          multi
);

  // Scan downward so the lowest set bit is the final assignment; idx stays 0 when none.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign none  = ~|vec;
  assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/ah_range_decoder_pipe.sv
// Two-stage programmable address-range decoder: S1 registers the hit vector, S2 the encoded result.
module ah_range_decoder_pipe
  import ah_dec_pkg::*;
#(
  parameter int ADDR_W      = 57,
  parameter int NUM_CLIENTS = 30,
  parameter int CNT_W       = 16,
  localparam int SEL_W      = $clog2(NUM_CLIENTS)
) (
  input logic                    clk,
  input logic                    reset_n,
  ah_range_decoder_pipe_if.slave bus
);

  logic [ADDR_W-1:0]      bom [NUM_CLIENTS];
  logic [ADDR_W-1:0]      tom [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] en;
  logic [NUM_CLIENTS-1:0] hit;
  logic [NUM_CLIENTS-1:0] s1_hit;
  logic                   s1_valid;
  logic                   s2_valid;
  logic [SEL_W-1:0]       s2_sel;
  logic [NUM_CLIENTS-1:0] s2_onehot;
  logic                   s2_err;
  logic                   s2_multi;
  logic [SEL_W-1:0]       enc_idx;
  logic                   enc_none;
  logic                   enc_multi;
  logic                   cfg_err_q;
  logic [CNT_W-1:0]       err_cnt_q;
  logic                   s2_adv;
  logic                   s1_adv;
  logic                   accept;
  logic                   cfg_legal;

  assign s2_adv      = !s2_valid || bus.out_ready;
  assign s1_adv      = !s1_valid || s2_adv;
  assign bus.in_ready = reset_n && s1_adv;
  assign accept      = bus.in_valid && bus.in_ready;
  assign cfg_legal   = (int'(bus.cfg_idx) < NUM_CLIENTS) && (bus.cfg_sel != CFG_RSVD);

  // Comparators read the registers before this edge's write, so a same-cycle write misses this lookup.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      hit[i] = en[i] && (bus.in_addr >= bom[i]) && (bus.in_addr <= tom[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        bom[i] <= {ADDR_W{BOM_RST_BIT}};
        tom[i] <= {ADDR_W{TOM_RST_BIT}};
      end
      en        <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we && !cfg_legal;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (bus.cfg_we && cfg_legal && (bus.cfg_idx == SEL_W'(i))) begin
          case (cfg_sel_e'(bus.cfg_sel))
            CFG_BOM: bom[i] <= bus.cfg_wdata;
            CFG_TOM: tom[i] <= bus.cfg_wdata;
            CFG_EN:  en[i]  <= bus.cfg_wdata[0];
            default: ;
          endcase
        end
      end
    end
  end

  ah_dec_prio_enc #(.N(NUM_CLIENTS)) u_prio_enc (
    .vec   (s1_hit),
    .idx   (enc_idx),
    .none  (enc_none),
    .multi (enc_multi)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_hit    <= '0;
      s2_valid  <= 1'b0;
      s2_sel    <= '0;
      s2_onehot <= '0;
      s2_err    <= 1'b0;
      s2_multi  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) s1_hit <= hit;
      end
      // S2 data only moves when a new result lands, holding it stable through a stall.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sel    <= enc_idx;
          s2_onehot <= s1_hit;
          s2_err    <= enc_none;
          s2_multi  <= enc_multi;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || bus.err_cnt_clr) begin
      err_cnt_q <= '0;
    end else if (s2_valid && bus.out_ready && s2_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_sel    = s2_sel;
  assign bus.out_onehot = s2_onehot;
  assign bus.out_err    = s2_err;
  assign bus.out_multi  = s2_multi;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule
